ps2_host_tx: RTL
================

# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the CPU side to the keyboard over the same two-wire bus that the Keyboard receiver listens on. It runs on the 25 MHz system clock. The PS/2 pins are driven open-drain through output-enable signals; the top level ties each pin low when its enable is 1 and tristates it otherwise. `tx_busy` gates the Keyboard receiver so that it ignores the bus while the host owns it.

## Interface
- `INHIBIT_CYCLES`, default 3000: clock-low hold before the request, 120 µs at 25 MHz.
- `REQ_CYCLES`, default 16: cycles during which both clock and data are held low before the clock is released.
- `TIMEOUT_CYCLES`, default 375000: 15 ms budget from clock release to the ACK sample.
- `clk`, in, 1: system clock (CLK_25MHZ).
- `reset`, in, 1: asynchronous, active-low.
- `tx_data`, in, 8: command byte.
- `tx_valid`, in, 1: transfer request.
- `tx_ready`, out, 1: block is idle and accepts a byte.
- `tx_busy`, out, 1: host owns the bus; equals `~tx_ready`.
- `tx_done`, out, 1: one-cycle pulse, device acknowledged.
- `tx_error`, out, 1: one-cycle pulse, no ACK or timeout.
- `ps2_clk_in`, in, 1: raw PS2_CLK pin, asynchronous.
- `ps2_data_in`, in, 1: raw PS2_DATA pin, asynchronous.
- `ps2_clk_oe`, out, 1: 1 pulls PS2_CLK low.
- `ps2_data_oe`, out, 1: 1 pulls PS2_DATA low.

## Operation
- Accept: a byte is taken when `tx_valid && tx_ready`.
  - `tx_data` is latched.
  - Parity is computed as `~^tx_data` (odd parity).
  - `tx_valid` while busy is ignored; nothing is queued.
- States: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
- IDLE: both enables 0, `tx_ready`=1.
- INHIBIT: `ps2_clk_oe`=1 and `ps2_data_oe`=0 for INHIBIT_CYCLES cycles.
- REQ: `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit) for REQ_CYCLES cycles.
- SEND:
  - `ps2_clk_oe`=0; the device now generates the clock.
  - The 10-bit frame is data[0..7], then parity, then stop=1; bit counter runs 0..9.
  - On each detected falling edge of the synchronised clock, the next frame bit is presented: `ps2_data_oe` = ~bit.
  - After the stop bit is presented (`ps2_data_oe`=0, line released) the FSM moves to ACK.
- ACK: on the next falling edge, sample `ps2_data_in`.
  - 0: ACK received; go to WAIT_IDLE with a pending done.
  - 1: go to WAIT_IDLE with a pending error.
- WAIT_IDLE: wait until synchronised clock and data are both 1, then go to IDLE and pulse `tx_done` or `tx_error` in that cycle.
- Timeout: a counter starts on entry to SEND. If it reaches TIMEOUT_CYCLES in SEND or ACK:
  - both enables drop to 0;
  - `tx_error` pulses;
  - the FSM goes directly to IDLE.
- Input conditioning: both pins pass through a 2-flop synchroniser. A falling edge is "previous synced = 1 and current synced = 0".

## Timing
- Reset values (asynchronous, immediate): state IDLE, both enables 0, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `tx_error`=0, counters 0. Asserting reset mid-frame releases both lines in the same instant.
- All outputs are registered.
- Accept at edge N: `ps2_clk_oe`=1 and `tx_ready`=0 from N+1.
- `ps2_data_oe` rises at N+1+INHIBIT_CYCLES.
- `ps2_clk_oe` falls at N+1+INHIBIT_CYCLES+REQ_CYCLES.
- Pin falling edge to `ps2_data_oe` update: at most 4 cycles. This is far inside the device's ≥30 µs clock-low phase.
- The ACK sample uses the same edge-detect path.
- `tx_done`/`tx_error` are exactly one cycle wide and mutually exclusive. `tx_ready` returns high in the same cycle as the pulse.
- Simultaneous timeout and ACK edge: the timeout wins.

## Structure
- Shared package `ps2_pkg`:
  - state enum;
  - command constants `PS2_CMD_SET_LED`=8'hED, `PS2_CMD_RESET`=8'hFF, `PS2_CMD_ENABLE`=8'hF4;
  - ACK byte 8'hFA.
- One sub-module, `ps2_line_sync`: 2-flop synchroniser plus falling-edge detector for clock and data. The Keyboard receiver reuses it.
- One shared down-counter serves the INHIBIT, REQ and timeout phases.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs:
  - data bits observed on falling edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `tx_done` pulses once; `tx_error` stays 0.
- Accept at cycle N with default parameters:
  - `ps2_clk_oe`=1 on cycles N+1..N+3016;
  - `ps2_data_oe` rises at N+3001;
  - clock released at N+3017.
- Device leaves data high on the 11th falling edge: `tx_error` pulses; `tx_done` stays 0.
- Device never clocks: `tx_error` at 375000 cycles after clock release, both enables 0, `tx_ready`=1.
- Reset asserted after the 4th data bit: both enables 0 immediately. After release, `tx_ready`=1 and a new 0xFF transfer completes normally.
- Send 0xFF, then assert `tx_valid` with 0xF4 while busy:
  - the second request is ignored until `tx_ready`;
  - re-presented after WAIT_IDLE, 0xF4 sends parity 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame layout and command bytes.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 10;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Host-to-device frame after the start bit; bit 0 goes out first.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  // Odd parity bit for a PS/2 byte.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser and falling-edge detector for the PS/2 clock and data pins.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall_c,
  output logic data_fall_c
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;
  logic data_prev_q, data_prev_d;

  // Shift each pin through meta -> sync -> prev.
  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
    data_prev_d = data_sync_q;
  end

  // Reset to the idle-high bus level so no edge is seen coming out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      data_prev_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      data_prev_q <= data_prev_d;
    end
  end

  assign clk_s       = clk_sync_q;
  assign data_s      = data_sync_q;
  assign clk_fall_c  = clk_prev_q & ~clk_sync_q;
  assign data_fall_c = data_prev_q & ~data_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 3000,
  parameter int unsigned REQ_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = max3(INHIBIT_CYCLES, REQ_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LOAD = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  ps2_tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  ack_ok_q, ack_ok_d;
  logic                  clk_oe_q, clk_oe_d;
  logic                  data_oe_q, data_oe_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic clk_s, data_s, clk_fall_c;
  // The data falling edge only matters to the keyboard receiver.
  logic unused_data_fall;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_s       (clk_s),
    .data_s      (data_s),
    .clk_fall_c  (clk_fall_c),
    .data_fall_c (unused_data_fall)
  );

  // Next-state and registered-output logic; the shared counter times every phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    ack_ok_d  = ack_ok_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          frame_d   = ps2_frame_t'{stop: 1'b1, parity: odd_parity(tx_data), data: tx_data};
          bit_cnt_d = '0;
          ack_ok_d  = 1'b0;
          cnt_d     = INH_LOAD;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d     = REQ_LOAD;
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_REQ: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
        if (cnt_q == '0) begin
          // Release the clock; the start bit stays on data until the first device edge.
          cnt_d    = TO_LOAD;
          clk_oe_d = 1'b0;
          state_d  = ST_SEND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SEND: begin
        data_oe_d = data_oe_q;
        if (cnt_q == '0) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (clk_fall_c) begin
            data_oe_d = ~frame_q[0];
            frame_d   = frame_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        // Timeout is checked first so it wins over a coincident ACK edge.
        if (cnt_q == '0) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (clk_fall_c) begin
            ack_ok_d = ~data_s;
            state_d  = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = ack_ok_q;
          error_d = ~ack_ok_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      ack_ok_q  <= ack_ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
